// File: rtl/max7219_rx_model.sv
// max7219_rx_model
//   Receive-only model of the MAX7219 serial interface. Samples SCK/DIN/LOAD
//   through synchronizers, assembles 16-bit frames and keeps a shadow copy of
//   the MAX7219 register file.
// Ports
//   clock, rst        system clock, synchronous active-high reset
//   i_sck/i_din/i_load serial lines (asynchronous to clock)
//   o_digits          digit registers, digit n (addr n+1) at [8n+7:8n]
//   o_decode_mode     reg 0x9; o_intensity reg 0xA[3:0]; o_scan_limit reg 0xB[2:0]
//   o_shutdown_n      reg 0xC bit0; o_disp_test reg 0xF bit0
//   o_wr_valid        one-cycle pulse per committed frame, with o_wr_addr/o_wr_data
//   o_frame_err       one-cycle pulse when load rose with fewer than 16 bits
//   o_state           FSM state (0 IDLE, 1 SHIFT, 2 COMMIT) for debug/monitoring
module max7219_rx_model #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        i_sck,
    input  logic        i_din,
    input  logic        i_load,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_disp_test,
    output logic        o_wr_valid,
    output logic [3:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_frame_err,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t r_state, w_next_state;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_din_sync, r_load_sync;
    logic                   r_sck_d, r_load_d;
    logic                   w_sck, w_din, w_load;
    logic                   w_sck_rise, w_load_rise, w_load_fall;

    logic [FRAME_BITS-1:0]  r_shift;
    logic [4:0]             r_cnt;

    logic [63:0] r_digits;
    logic [7:0]  r_decode_mode;
    logic [3:0]  r_intensity;
    logic [2:0]  r_scan_limit;
    logic        r_shutdown_n;
    logic        r_disp_test;

    logic        w_commit_ok;
    logic        w_frame_err;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [2:0]  w_digit_idx;

    // Synchronizers plus one edge-detect flop. Resetting to 0 means a load
    // already low at reset release never looks like a falling edge, so a
    // frame only starts after a full high->low sequence.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_din_sync  <= '0;
            r_load_sync <= '0;
            r_sck_d     <= 1'b0;
            r_load_d    <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], i_din};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], i_load};
            r_sck_d     <= w_sck;
            r_load_d    <= w_load;
        end
    end

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_load      = r_load_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_load_rise = w_load & ~r_load_d;
    assign w_load_fall = ~w_load & r_load_d;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_load_fall) w_next_state = SHIFT;
            SHIFT:   if (w_load_rise) w_next_state = COMMIT;
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_commit_ok = 1'b0;
        w_frame_err = 1'b0;
        if (r_state == COMMIT) begin
            w_commit_ok = (r_cnt == 5'(FRAME_BITS));
            w_frame_err = (r_cnt != 5'(FRAME_BITS));
        end
    end

    assign w_addr      = r_shift[11:8];
    assign w_data      = r_shift[7:0];
    assign w_digit_idx = 3'(w_addr - 4'd1);

    // Shift register and bit counter. A load rise in SHIFT wins over a
    // coincident sck rise; the counter saturates so over-long frames keep
    // the last 16 bits (daisy-chain behaviour).
    always_ff @(posedge clock) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_state == IDLE && w_load_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (r_state == SHIFT && !w_load_rise && w_sck_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_din};
            if (r_cnt != 5'(FRAME_BITS)) r_cnt <= r_cnt + 5'd1;
        end
    end

    // Shadow register file, written in the COMMIT cycle
    always_ff @(posedge clock) begin
        if (rst) begin
            r_digits      <= '0;
            r_decode_mode <= '0;
            r_intensity   <= '0;
            r_scan_limit  <= '0;
            r_shutdown_n  <= 1'b0;
            r_disp_test   <= 1'b0;
        end else if (w_commit_ok) begin
            case (w_addr)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                    r_digits[{w_digit_idx, 3'b000} +: 8] <= w_data;
                4'h9: r_decode_mode <= w_data;
                4'hA: r_intensity   <= w_data[3:0];
                4'hB: r_scan_limit  <= w_data[2:0];
                4'hC: r_shutdown_n  <= w_data[0];
                4'hF: r_disp_test   <= w_data[0];
                default: ;  // 0x0 no-op, 0xD/0xE unused
            endcase
        end
    end

    assign o_digits      = r_digits;
    assign o_decode_mode = r_decode_mode;
    assign o_intensity   = r_intensity;
    assign o_scan_limit  = r_scan_limit;
    assign o_shutdown_n  = r_shutdown_n;
    assign o_disp_test   = r_disp_test;
    assign o_wr_valid    = w_commit_ok;
    assign o_wr_addr     = w_commit_ok ? w_addr : 4'h0;
    assign o_wr_data     = w_commit_ok ? w_data : 8'h00;
    assign o_frame_err   = w_frame_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_max7219_rx_model.sv
// Bench for max7219_rx_model: directed frames on the serial lines, a monitor
// that pops expected {err, addr, data} entries on every output pulse, and
// direct checks of the shadow registers between frames.
module tb_max7219_rx_model;

    logic        clock = 1'b0;
    logic        rst;
    logic        sck, din, load;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, disp_test;
    logic        wr_valid, frame_err;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected pulses: bit 12 = frame_err, [11:8] addr, [7:0] data
    logic [12:0] exp_q[$];

    localparam int HALF = 6;  // clocks per sck phase, >= SYNC_STAGES+2

    max7219_rx_model #(.SYNC_STAGES(2)) dut (
        .clock        (clock),
        .rst          (rst),
        .i_sck        (sck),
        .i_din        (din),
        .i_load       (load),
        .o_digits     (digits),
        .o_decode_mode(decode_mode),
        .o_intensity  (intensity),
        .o_scan_limit (scan_limit),
        .o_shutdown_n (shutdown_n),
        .o_disp_test  (disp_test),
        .o_wr_valid   (wr_valid),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_frame_err  (frame_err),
        .o_state      (state)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every wr_valid / frame_err pulse must match the head of exp_q
    always @(negedge clock) begin
        if (!rst && (wr_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {51'd0, frame_err, wr_addr, wr_data}, 64'h1fff_dead);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("pulse", {49'd0, wr_valid, frame_err, wr_addr, wr_data},
                      {49'd0, ~e[12], e[12], (e[12] ? 12'h000 : e[11:0])});
            end
        end
    end

    // Driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            din = bits[i];
            sck = 1'b0;
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
        end
        sck = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits);
        load = 1'b0;
        wait_clk(HALF);
        shift_bits(bits, nbits);
        load = 1'b1;
        wait_clk(10);
    endtask

    // Directed sequence
    initial begin
        rst = 1'b1; sck = 1'b0; din = 1'b0; load = 1'b1;
        wait_clk(5);
        check("rst_digits", digits, 64'd0);
        check("rst_misc", {decode_mode, intensity, scan_limit, shutdown_n, disp_test},
              {8'd0, 4'd0, 3'd0, 1'b0, 1'b0});
        check("rst_pulses", {wr_valid, frame_err, wr_addr, wr_data}, 14'd0);
        check("rst_state", state, 2'd0);
        rst = 1'b0;
        wait_clk(10);

        // T1 shutdown register
        exp_q.push_back({1'b0, 12'hC01});
        send_frame(32'h0C01, 16);
        check("t1_shutdown_n", shutdown_n, 1'b1);

        // T2 intensity / decode / scan limit
        exp_q.push_back({1'b0, 12'hA07});
        send_frame(32'h0A07, 16);
        exp_q.push_back({1'b0, 12'h9FF});
        send_frame(32'h09FF, 16);
        exp_q.push_back({1'b0, 12'hB07});
        send_frame(32'h0B07, 16);
        check("t2_intensity", intensity, 4'd7);
        check("t2_decode_mode", decode_mode, 8'hFF);
        check("t2_scan_limit", scan_limit, 3'd7);

        // T3 all eight digits, data = digit index
        for (int d = 0; d < 8; d++) begin
            logic [3:0] a;
            logic [7:0] v;
            a = 4'(d + 1);
            v = 8'(d);
            exp_q.push_back({1'b0, a, v});
            send_frame({20'd0, a, v}, 16);
        end
        check("t3_digits", digits, 64'h0706050403020100);

        // T4 short frame (12 bits): error pulse, nothing written
        exp_q.push_back(13'h1000);
        send_frame(32'h0F01, 12);
        check("t4_disp_test", disp_test, 1'b0);
        check("t4_digits", digits, 64'h0706050403020100);
        check("t4_regs", {decode_mode, intensity, scan_limit, shutdown_n},
              {8'hFF, 4'd7, 3'd7, 1'b1});

        // T5 24-bit frame keeps the last 16 bits
        exp_q.push_back({1'b0, 12'h305});
        send_frame(32'hAB0305, 24);
        check("t5_digit2", digits[23:16], 8'h05);
        check("t5_digits", digits, 64'h0706050403050100);

        // T6 reset after 8 bits, load still low when reset released
        load = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h0F, 8);
        rst = 1'b1;
        wait_clk(4);
        check("t6_rst_digits", digits, 64'd0);
        rst = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h01, 8);
        load = 1'b1;  // first rise after reset: no frame_err expected
        wait_clk(10);
        check("t6_disp_test_low", disp_test, 1'b0);
        check("t6_state_idle", state, 2'd0);
        exp_q.push_back({1'b0, 12'hF01});
        send_frame(32'h0F01, 16);
        check("t6_disp_test_high", disp_test, 1'b1);

        // No-op and unused addresses still pulse but change nothing
        exp_q.push_back({1'b0, 12'h055});
        send_frame(32'h7055, 16);
        exp_q.push_back({1'b0, 12'hD01});
        send_frame(32'h0D01, 16);
        check("noop_regs", {digits, decode_mode, intensity, scan_limit, shutdown_n, disp_test},
              {64'd0, 8'd0, 4'd0, 3'd0, 1'b0, 1'b1});

        wait_clk(5);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
